// File: rtl/result_checker_if.sv
// Bus between the processor result stream and the result_checker self-check stage.
interface result_checker_if #(
   parameter int unsigned DATA_W = 32
) ();
   logic [DATA_W-1:0] result_i;
   logic              hold_i;
   logic [5:0]        score_o;
   logic [4:0]        idx_o;
   logic              done_o;
   logic              pass_o;
   logic [4:0]        first_fail_idx_o;
   logic [DATA_W-1:0] first_fail_data_o;
   logic              fail_seen_o;

   modport master (
      output result_i, hold_i,
      input  score_o, idx_o, done_o, pass_o,
      input  first_fail_idx_o, first_fail_data_o, fail_seen_o
   );

   modport slave (
      input  result_i, hold_i,
      output score_o, idx_o, done_o, pass_o,
      output first_fail_idx_o, first_fail_data_o, fail_seen_o
   );
endinterface

// File: rtl/result_checker.sv
// Compares the processor result stream against a fixed reference ROM and scores matches.
// Optional first-mismatch capture is enabled with RESULT_CHECKER_FIRSTFAIL_EN.
module result_checker #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_CHECKS  = 20,
   parameter int unsigned START_DELAY = 1
) (
   input  logic clk,
   input  logic reset,
   result_checker_if.slave bus
);

   localparam logic [1:0] ST_WAIT  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0] ST_RESET = (START_DELAY > 0) ? ST_WAIT : ST_CHECK;
   localparam logic [3:0] DLY_LAST = 4'(START_DELAY - 1);
   localparam logic [5:0] IDX_LAST = 6'(NUM_CHECKS - 1);
   localparam logic [5:0] SCORE_FULL = 6'(NUM_CHECKS);

   logic [1:0]        state_q, state_d;
   logic [3:0]        dly_q, dly_d;
   logic [5:0]        score_q, score_d;
   // One extra bit so the index can rest at NUM_CHECKS = 32 without wrapping.
   logic [5:0]        idx_q, idx_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [DATA_W-1:0] expected_c;

   // Reference sequence of the directed instruction program.
   function automatic logic [DATA_W-1:0] rom_at(input logic [4:0] i);
      logic [31:0] v;
      case (i)
         5'd0:  v = 32'h0000_0000;
         5'd1:  v = 32'h0000_0001;
         5'd2:  v = 32'h0000_0002;
         5'd3:  v = 32'h0000_0004;
         5'd4:  v = 32'h0000_0005;
         5'd5:  v = 32'h0000_0007;
         5'd6:  v = 32'h0000_0008;
         5'd7:  v = 32'h0000_000B;
         5'd8:  v = 32'h0000_0003;
         5'd9:  v = 32'hFFFF_FFFE;
         5'd10: v = 32'h0000_0000;
         5'd11: v = 32'h0000_0005;
         5'd12: v = 32'h0000_0001;
         5'd13: v = 32'hFFFF_FFF4;
         5'd14: v = 32'h0000_04D2;
         5'd15: v = 32'hFFFF_F8D7;
         5'd16: v = 32'h0000_0001;
         5'd17: v = 32'hFFFF_FB2C;
         5'd18: v = 32'h0000_0030;
         5'd19: v = 32'h0000_0030;
         default: v = 32'h0000_0000;
      endcase
      return DATA_W'(v);
   endfunction

   assign expected_c = rom_at(idx_q[4:0]);

   // State and score registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RESET;
         dly_q   <= '0;
         score_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         score_q <= score_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state and scoring logic.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      score_d = score_q;
      idx_d   = idx_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         ST_WAIT: begin
            dly_d = dly_q + 4'd1;
            if (dly_q == DLY_LAST) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!bus.hold_i) begin
               if (bus.result_i == expected_c) score_d = score_q + 6'd1;
               idx_d = idx_q + 6'd1;
               // done/pass commit on the same edge as the final sample.
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (score_d == SCORE_FULL);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   assign bus.score_o = score_q;
   assign bus.idx_o   = idx_q[4:0];
   assign bus.done_o  = done_q;
   assign bus.pass_o  = pass_q;

`ifdef RESULT_CHECKER_FIRSTFAIL_EN
   logic              mismatch_c;
   logic              fail_seen_q;
   logic [4:0]        fail_idx_q;
   logic [DATA_W-1:0] fail_data_q;

   assign mismatch_c = (state_q == ST_CHECK) && !bus.hold_i && (bus.result_i != expected_c);

   // Sticky capture of the first mismatching sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fail_seen_q <= 1'b0;
         fail_idx_q  <= '0;
         fail_data_q <= '0;
      end else if (mismatch_c && !fail_seen_q) begin
         fail_seen_q <= 1'b1;
         fail_idx_q  <= idx_q[4:0];
         fail_data_q <= bus.result_i;
      end
   end

   assign bus.fail_seen_o       = fail_seen_q;
   assign bus.first_fail_idx_o  = fail_idx_q;
   assign bus.first_fail_data_o = fail_data_q;
`else
   assign bus.fail_seen_o       = 1'b0;
   assign bus.first_fail_idx_o  = '0;
   assign bus.first_fail_data_o = '0;
`endif

endmodule

// File: doc/result_checker.md
# result_checker

Synthesizable self-check stage that sits directly downstream of `processor` and consumes its 32-bit `Result` bus, one value per clock. It compares each sampled result against a fixed expected-value ROM holding the directed instruction program's reference sequence, and counts matches. It raises `done` and `pass` so the score is available on-chip (FPGA LEDs, simulation) without a behavioural bench.

## Interface
- `DATA_W`, 32: width of the result bus.
- `NUM_CHECKS`, 20: number of results compared; legal range 1..32.
- `START_DELAY`, 1: clock edges after reset deassertion before the first sample; legal range 0..15.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `result_i`  in  DATA_W  processor `Result` bus.
- `hold_i`  in  1  stall; when 1 the current cycle is not sampled.
- `score_o`  out  6  count of matching samples.
- `idx_o`  out  5  index of the next ROM entry to compare.
- `done_o`  out  1  all NUM_CHECKS samples taken (sticky).
- `pass_o`  out  1  done and score == NUM_CHECKS (sticky).
- `first_fail_idx_o`  out  5  index of the first mismatch.
- `first_fail_data_o`  out  DATA_W  value sampled at the first mismatch.
- `fail_seen_o`  out  1  at least one mismatch recorded.

## Operation
- **Expected ROM, index 0..19:** 0x0, 0x1, 0x2, 0x4, 0x5, 0x7, 0x8, 0xB, 0x3, 0xFFFFFFFE, 0x0, 0x5, 0x1, 0xFFFFFFF4, 0x4D2, 0xFFFFF8D7, 0x1, 0xFFFFFB2C, 0x30, 0x30. Entries 20..31 are 0.
- **States:** WAIT, CHECK, DONE.
- **Reset state:** WAIT if START_DELAY > 0, else CHECK.
- **WAIT:** a 4-bit delay counter increments each edge. Transition to CHECK on the edge where the counter reaches START_DELAY-1. `hold_i` is ignored in WAIT.
- **CHECK, `hold_i` = 0:**
  - Compare `result_i` with ROM[`idx_o`] over the full DATA_W bits.
  - On match, `score_o` += 1.
  - `idx_o` += 1.
  - If `idx_o` == NUM_CHECKS-1, go to DONE.
- **CHECK, `hold_i` = 1:** no compare; all registers hold.
- **DONE:** `done_o` = 1; `pass_o` = (`score_o` == NUM_CHECKS). `result_i` and `hold_i` are ignored. The block stays in DONE until reset.
- **Arithmetic:** `score_o` cannot exceed NUM_CHECKS, so there is no saturation logic. `idx_o` never wraps; it freezes at NUM_CHECKS in DONE.

## Timing
- **Reset values (asynchronous, all outputs):** `score_o` = 0, `idx_o` = 0, `done_o` = 0, `pass_o` = 0, `fail_seen_o` = 0, `first_fail_idx_o` = 0, `first_fail_data_o` = 0. The delay counter is also cleared.
- **First sample:** taken on the (START_DELAY+1)-th rising edge after `reset` falls.
- **Output latency:** `score_o`, `idx_o` and the fail outputs are registered. They reflect a sample one cycle after the sampling edge.
- **`done_o` / `pass_o`:** rise together on the same edge that commits the last sample, so `score_o` is final in that cycle.
- **Reset during CHECK or DONE:** immediate return to reset values; a new run starts from index 0.
- **`hold_i` asserted on the final sample cycle:** the final sample is deferred; `done_o` does not rise until a non-held edge.

## Configuration
- **Macro:** `RESULT_CHECKER_FIRSTFAIL_EN`.
- **Defined:**
  - On the first mismatch in CHECK, capture `idx_o` into `first_fail_idx_o` and `result_i` into `first_fail_data_o`, and set `fail_seen_o`.
  - All three are sticky; later mismatches do not overwrite them.
- **Undefined:** `first_fail_idx_o`, `first_fail_data_o` and `fail_seen_o` are tied to 0 and no capture registers are built. Scoring is unchanged.

## Test plan
- **Correct stream:** reset, then drive the 20 ROM values in order with `hold_i` = 0 and START_DELAY = 1 -> `score_o` = 20, `done_o` = `pass_o` = 1, 21 edges after `reset` falls, `fail_seen_o` = 0.
- **Single error:** drive 0xFFFFFFFD instead of 0xFFFFFFFE at index 9 -> `score_o` = 19, `pass_o` = 0, `done_o` = 1. With the macro: `first_fail_idx_o` = 9, `first_fail_data_o` = 0xFFFFFFFD, `fail_seen_o` = 1. Without the macro: all three read 0.
- **Stall:** assert `hold_i` for 3 cycles at index 5 while driving garbage (0xDEADBEEF) -> no score change, `idx_o` holds at 5. The run completes with `score_o` = 20, 3 cycles later than the correct-stream case.
- **Mid-run reset:** assert `reset` asynchronously at index 10 with `score_o` = 10 -> all outputs read 0 before the next edge. A following correct stream yields `score_o` = 20 and `pass_o` = 1.
- **Post-done input:** after `done_o` = 1, drive 0x0 for 10 cycles -> `score_o`, `idx_o` = 20 and `pass_o` are unchanged.
- **No start delay:** START_DELAY = 0, correct stream from the first edge after `reset` falls -> `score_o` = 20, `done_o` = 1 after exactly 20 edges.
